cim_shift_acc: RTL

Multi-channel, parametrised bit-serial shift-accumulator for the CIM macro output path. Each lane receives one signed partial sum per input-bit plane (MSB plane first) from the global adder tree. Each lane computes acc = (acc << 1) + din over NBITS beats. Optional two's-complement MSB weighting and optional saturation are supported. A small controller sequences the pass and issues a result strobe, replacing the single-lane free-running accumulator with a start/valid handshake.

---
 rtl/cim_acc_pkg.sv | 37 +++
 rtl/cim_acc_lane.sv | 61 ++++++
 rtl/cim_shift_acc.sv | 88 ++++++++
 3 files changed

// File: rtl/cim_acc_pkg.sv
// Shared types and helpers for the bit-serial CIM shift-accumulator.
// sat_acc works at a fixed wide width so any lane width up to WMAX-2 can share it.
package cim_acc_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam int unsigned WMAX = 128;

  typedef struct packed {
    logic            ovf;
    logic [WMAX-1:0] val;
  } sat_res_t;

  // Range-checks a signed value against a signed `width`-bit window.
  // Out of range: flags ovf and clamps when sat is set, else passes the value through
  // so the caller's truncation yields the wrapped result.
  function automatic sat_res_t sat_acc(input logic signed [WMAX-1:0] value,
                                       input int unsigned width,
                                       input logic sat);
    logic signed [WMAX-1:0] one, hi, lo;
    sat_res_t res;
    one = {{(WMAX-1){1'b0}}, 1'b1};
    hi  = (one <<< (width - 1)) - one;
    lo  = ~hi;
    res.ovf = 1'b0;
    res.val = value;
    if (value > hi) begin
      res.ovf = 1'b1;
      if (sat) res.val = hi;
    end else if (value < lo) begin
      res.ovf = 1'b1;
      if (sat) res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/cim_acc_lane.sv
// One accumulator lane: acc <= (acc << 1) +/- din with overflow detect and sat/wrap.
module cim_acc_lane
  import cim_acc_pkg::*;
#(
  parameter int unsigned DIN_W     = 27,
  parameter int unsigned ACC_W     = 51,
  parameter bit          SIGNED_IN = 1'b1,
  parameter bit          SAT       = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic             first_beat,
  input  logic [DIN_W-1:0] din,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  logic [ACC_W-1:0]       acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic signed [WMAX-1:0] base, din_ext, next_v;
  sat_res_t               res;
  logic                   unused_hi;

  always_comb begin
    // A clear in the same cycle as a beat makes that beat start from zero.
    base    = clr ? '0 : {{(WMAX-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    din_ext = {{(WMAX-DIN_W){din[DIN_W-1]}}, din};
    if (SIGNED_IN && first_beat) next_v = (base <<< 1) - din_ext;
    else                         next_v = (base <<< 1) + din_ext;
    res = sat_acc(next_v, ACC_W, SAT);

    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
    if (en) begin
      acc_d = res.val[ACC_W-1:0];
      ovf_d = (ovf_q & ~clr) | res.ovf;
    end
  end

  assign unused_hi = ^res.val[WMAX-1:ACC_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/cim_shift_acc.sv
// Multi-lane bit-serial shift-accumulator: pass sequencing FSM, beat counter and lane array.
module cim_shift_acc
  import cim_acc_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter int unsigned DIN_W     = 27,
  parameter int unsigned ACC_W     = 51,
  parameter int unsigned NBITS     = 8,
  parameter bit          SIGNED_IN = 1'b1,
  parameter bit          SAT       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 din_valid,
  input  logic [NCH*DIN_W-1:0] din,
  output logic                 busy,
  output logic                 dout_valid,
  output logic [NCH*ACC_W-1:0] dout,
  output logic [NCH-1:0]       ovf
);

  localparam int unsigned     CNT_W   = 7;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NBITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic             busy_q, busy_d, valid_q, valid_d;
  logic             accept, last, first_beat;

  always_comb begin
    // start restarts the pass, so the current cycle's beat counts as beat 0.
    cnt_eff    = start ? '0 : cnt_q;
    accept     = din_valid & (start | (state_q == StAccum));
    last       = accept & (cnt_eff == LastCnt);
    first_beat = (cnt_eff == '0);

    state_d = state_q;
    cnt_d   = cnt_q;
    if (start || (state_q == StAccum)) begin
      state_d = last ? StDone : StAccum;
      if (!accept)   cnt_d = cnt_eff;
      else if (last) cnt_d = '0;
      else           cnt_d = cnt_eff + CNT_W'(1);
    end else if (state_q == StDone) begin
      state_d = StIdle;
    end

    busy_d  = (state_d == StAccum);
    valid_d = last;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy       = busy_q;
  assign dout_valid = valid_q;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    cim_acc_lane #(
      .DIN_W    (DIN_W),
      .ACC_W    (ACC_W),
      .SIGNED_IN(SIGNED_IN),
      .SAT      (SAT)
    ) u_lane (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (start),
      .en        (accept),
      .first_beat(first_beat),
      .din       (din[i*DIN_W +: DIN_W]),
      .acc       (dout[i*ACC_W +: ACC_W]),
      .ovf       (ovf[i])
    );
  end

endmodule
